// File: rtl/ext_mem_if_pkg.sv
// Shared definitions for the external memory interface: FSM states and the
// default memory map used by the core, the interface and the bench.
package ext_mem_if_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } mem_state_t;

   localparam int unsigned DATA_W       = 16;
   localparam int unsigned CNT_W        = 4;
   localparam logic [15:0] ROM_TOP_DEF  = 16'h07FF;
   localparam int unsigned ROM_WAIT_DEF = 2;
   localparam int unsigned RAM_WAIT_DEF = 1;

endpackage

// File: rtl/wait_counter.sv
// Loadable down-counter with zero flag; stalls at zero, clear beats load.
module wait_counter #(
   parameter int unsigned CNT_W = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clr,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n)
         r_cnt <= '0;
      else if (i_clr)
         r_cnt <= '0;
      else if (i_load)
         r_cnt <= i_load_val;
      else if (i_dec && (r_cnt != '0))
         r_cnt <= r_cnt - CNT_W'(1);
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/ext_mem_if.sv
// Bridges the core's multiplexed memory bus to a demultiplexed async SRAM/ROM,
// inserting per-region wait states and blocking writes into the ROM window.
module ext_mem_if
   import ext_mem_if_pkg::*;
#(
   parameter int unsigned ADDR_W   = 16,
   parameter logic [15:0] ROM_TOP  = ROM_TOP_DEF,
   parameter int unsigned ROM_WAIT = ROM_WAIT_DEF,
   parameter int unsigned RAM_WAIT = RAM_WAIT_DEF
) (
   input  logic              Clock,
   input  logic              nReset,
   input  logic [15:0]       CpuDataOut,
   input  logic              CpuALE,
   input  logic              CpuNME,
   input  logic              CpuNOE,
   input  logic              CpuRnW,
   output logic [15:0]       CpuDataIn,
   output logic              CpuNWait,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [15:0]       MemWData,
   input  logic [15:0]       MemRData,
   output logic              MemCE_n,
   output logic              MemOE_n,
   output logic              MemWE_n,
   output logic              WrErr
);

   mem_state_t       r_state;
   mem_state_t       w_next;
   logic [15:0]      r_addr;
   logic [15:0]      r_rd;
   logic [15:0]      r_wd;
   logic             r_read;
   logic             r_wrerr;
   logic             w_is_rom;
   logic [CNT_W-1:0] w_wait;
   logic             w_start;
   logic             w_abort;
   logic             w_finish;
   logic             w_cnt_zero;

   assign w_is_rom = (r_addr <= ROM_TOP);
   assign w_wait   = w_is_rom ? CNT_W'(ROM_WAIT) : CNT_W'(RAM_WAIT);

   always_ff @(posedge Clock) begin
      if (!nReset)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   // Next state plus the strobes, which follow state and the live bus.
   always_comb begin
      w_next    = r_state;
      w_start   = 1'b0;
      w_abort   = 1'b0;
      w_finish  = 1'b0;
      MemCE_n   = 1'b1;
      MemOE_n   = 1'b1;
      MemWE_n   = 1'b1;
      CpuNWait  = 1'b1;
      CpuDataIn = r_rd;
      case (r_state)
         IDLE: begin
            if (!CpuALE && !CpuNME) begin
               w_next  = ACCESS;
               w_start = 1'b1;
            end
         end
         ACCESS: begin
            MemCE_n  = 1'b0;
            CpuNWait = w_cnt_zero;
            MemOE_n  = !(r_read && !CpuNOE);
            MemWE_n  = r_read || w_is_rom;
            if (r_read)
               CpuDataIn = MemRData;
            if (CpuNME) begin
               w_next  = IDLE;
               w_abort = 1'b1;
            end else if (w_cnt_zero) begin
               w_next   = DONE;
               w_finish = 1'b1;
            end
         end
         DONE: begin
            if (CpuNME)
               w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Address, write data, read capture and the ROM-write error flag.
   always_ff @(posedge Clock) begin
      if (!nReset) begin
         r_addr  <= '0;
         r_rd    <= '0;
         r_wd    <= '0;
         r_read  <= 1'b0;
         r_wrerr <= 1'b0;
      end else begin
         r_wrerr <= w_start && !CpuRnW && w_is_rom;
         if ((r_state == IDLE) && CpuALE)
            r_addr <= CpuDataOut;
         if (w_start) begin
            r_read <= CpuRnW;
            if (!CpuRnW)
               r_wd <= CpuDataOut;
         end
         if (w_finish && r_read)
            r_rd <= MemRData;
      end
   end

   wait_counter #(.CNT_W(CNT_W)) u_wait_counter (
      .i_clk      (Clock),
      .i_rst_n    (nReset),
      .i_clr      (w_abort),
      .i_load     (w_start),
      .i_load_val (w_wait),
      .i_dec      (r_state == ACCESS),
      .o_zero     (w_cnt_zero)
   );

   assign MemAddr  = r_addr[ADDR_W-1:0];
   assign MemWData = r_wd;
   assign WrErr    = r_wrerr;

endmodule

// File: tb/tb_ext_mem_if.sv
// Randomized bench for ext_mem_if: each bus transaction is checked cycle by
// cycle against expectations derived from the region map and access rules.
module tb_ext_mem_if;
   import ext_mem_if_pkg::*;

   logic        Clock;
   logic        nReset;
   logic [15:0] CpuDataOut;
   logic        CpuALE;
   logic        CpuNME;
   logic        CpuNOE;
   logic        CpuRnW;
   logic [15:0] CpuDataIn;
   logic        CpuNWait;
   logic [15:0] MemAddr;
   logic [15:0] MemWData;
   logic [15:0] MemRData;
   logic        MemCE_n;
   logic        MemOE_n;
   logic        MemWE_n;
   logic        WrErr;

   int          n_cmp;
   int          n_err;
   logic [15:0] m_rd;

   ext_mem_if #(
      .ADDR_W   (16),
      .ROM_TOP  (ROM_TOP_DEF),
      .ROM_WAIT (ROM_WAIT_DEF),
      .RAM_WAIT (RAM_WAIT_DEF)
   ) u_dut (
      .Clock      (Clock),
      .nReset     (nReset),
      .CpuDataOut (CpuDataOut),
      .CpuALE     (CpuALE),
      .CpuNME     (CpuNME),
      .CpuNOE     (CpuNOE),
      .CpuRnW     (CpuRnW),
      .CpuDataIn  (CpuDataIn),
      .CpuNWait   (CpuNWait),
      .MemAddr    (MemAddr),
      .MemWData   (MemWData),
      .MemRData   (MemRData),
      .MemCE_n    (MemCE_n),
      .MemOE_n    (MemOE_n),
      .MemWE_n    (MemWE_n),
      .WrErr      (WrErr)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_ce"},    16'(MemCE_n),  16'd1);
      chk({tag, "_oe"},    16'(MemOE_n),  16'd1);
      chk({tag, "_we"},    16'(MemWE_n),  16'd1);
      chk({tag, "_nwait"}, 16'(CpuNWait), 16'd1);
      chk({tag, "_wrerr"}, 16'(WrErr),    16'd0);
      chk({tag, "_din"},   CpuDataIn,     m_rd);
   endtask

   task automatic check_reset(input string tag);
      check_idle(tag);
      chk({tag, "_addr"},  MemAddr,  16'h0000);
      chk({tag, "_wdata"}, MemWData, 16'h0000);
   endtask

   // One framed access; abort_k / reset_k pick an ACCESS cycle to cut it short (-1 = none).
   task automatic access(input logic [15:0] addr, input bit rd, input logic [15:0] wdata,
                         input bit fix_rd, input logic [15:0] rdat, input bit ale_nme,
                         input int abort_k, input int reset_k, input int n_done);
      bit          rom;
      int          w;
      logic [15:0] cur_rd;
      rom = (addr <= ROM_TOP_DEF);
      w   = rom ? int'(ROM_WAIT_DEF) : int'(RAM_WAIT_DEF);

      CpuALE = 1'b1; CpuDataOut = addr; CpuNME = !ale_nme; CpuRnW = rd; CpuNOE = 1'b1;
      MemRData = 16'($urandom);
      #2 check_idle("adr");
      tick();

      CpuALE = 1'b0; CpuNME = 1'b0; CpuNOE = !rd;
      CpuDataOut = rd ? 16'($urandom) : wdata;
      #2 check_idle("start");
      chk("start_addr", MemAddr, addr);
      tick();

      for (int k = 0; k <= w; k++) begin
         cur_rd     = fix_rd ? rdat : 16'($urandom);
         MemRData   = cur_rd;
         CpuALE     = 1'($urandom);
         CpuDataOut = 16'($urandom);
         CpuRnW     = 1'($urandom);
         if (rd) CpuNOE = ($urandom_range(0, 3) == 0);
         if (k == abort_k) CpuNME = 1'b1;
         if (k == reset_k) nReset = 1'b0;
         #2;
         chk("acc_ce",    16'(MemCE_n),  16'd0);
         chk("acc_nwait", 16'(CpuNWait), (k < w) ? 16'd0 : 16'd1);
         chk("acc_oe",    16'(MemOE_n),  (rd && !CpuNOE) ? 16'd0 : 16'd1);
         chk("acc_we",    16'(MemWE_n),  (!rd && !rom) ? 16'd0 : 16'd1);
         chk("acc_wrerr", 16'(WrErr),    (!rd && rom && k == 0) ? 16'd1 : 16'd0);
         chk("acc_addr",  MemAddr,       addr);
         chk("acc_din",   CpuDataIn,     rd ? cur_rd : m_rd);
         if (!rd && !rom) chk("acc_wdata", MemWData, wdata);
         tick();
         if (k == reset_k) begin
            CpuALE = 1'b0; CpuNME = 1'b1;
            m_rd = 16'h0000;
            #2 check_reset("rst");
            nReset = 1'b1;
            tick();
            return;
         end
         if (k == abort_k) begin
            CpuALE = 1'b0;
            #2 check_idle("abort");
            tick();
            return;
         end
         if (k == w && rd) m_rd = cur_rd;
      end

      for (int d = 0; d < n_done; d++) begin
         CpuALE = 1'($urandom); CpuDataOut = 16'($urandom); MemRData = 16'($urandom);
         #2 check_idle("done");
         chk("done_addr", MemAddr, addr);
         tick();
      end
      CpuALE = 1'b0; CpuNME = 1'b1;
      #2 check_idle("ret");
      tick();
   endtask

   initial begin
      n_cmp = 0; n_err = 0; m_rd = 16'h0000;
      nReset = 1'b0; CpuDataOut = 16'h0; CpuALE = 1'b0; CpuNME = 1'b1;
      CpuNOE = 1'b1; CpuRnW = 1'b1; MemRData = 16'h0;
      tick(); tick();
      #2 check_reset("por");
      nReset = 1'b1;
      tick();

      access(16'h1234, 1'b1, 16'h0,    1'b1, 16'hBEEF, 1'b0, -1, -1, 1);
      chk("ram_rd_beef", CpuDataIn, 16'hBEEF);
      access(16'h2000, 1'b0, 16'hA5A5, 1'b0, 16'h0,    1'b0, -1, -1, 1);
      access(16'h0010, 1'b1, 16'h0,    1'b0, 16'h0,    1'b0, -1, -1, 0);
      access(16'h07FF, 1'b0, 16'h5A5A, 1'b0, 16'h0,    1'b0, -1, -1, 1);
      access(16'h0800, 1'b0, 16'h1357, 1'b0, 16'h0,    1'b0, -1, -1, 2);
      access(16'h0010, 1'b1, 16'h0,    1'b0, 16'h0,    1'b0,  0, -1, 0);
      access(16'h3000, 1'b0, 16'hC3C3, 1'b0, 16'h0,    1'b0, -1,  1, 0);
      access(16'h4321, 1'b1, 16'h0,    1'b0, 16'h0,    1'b1, -1, -1, 1);

      for (int t = 0; t < 200; t++) begin
         logic [15:0] a;
         int          sel;
         int          w;
         int          ab;
         int          rs;
         sel = $urandom_range(0, 5);
         case (sel)
            0:       a = 16'h07FF;
            1:       a = 16'h0800;
            2:       a = 16'h0000;
            3:       a = 16'hFFFF;
            4:       a = 16'($urandom_range(0, 16'h07FF));
            default: a = 16'($urandom);
         endcase
         w  = (a <= ROM_TOP_DEF) ? int'(ROM_WAIT_DEF) : int'(RAM_WAIT_DEF);
         ab = -1; rs = -1;
         if ($urandom_range(0, 7) == 0)      ab = $urandom_range(0, w);
         else if ($urandom_range(0, 15) == 0) rs = $urandom_range(0, w);
         access(a, 1'($urandom), 16'($urandom), 1'b0, 16'h0, 1'($urandom),
                ab, rs, $urandom_range(0, 2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ext_mem_if.md
Name: ext_mem_if

Overview:
- Downstream neighbour of the CPU core's memory port.
- Consumes the core's multiplexed bus: ALE-latched address on Data_out, then nME/nOE/RnW strobes.
- Drives a demultiplexed external async SRAM/ROM and returns read data to the core.
- Stretches each access with nWait for a per-region number of wait states; rejects writes to the ROM region.

Parameters:
- ADDR_W, 16, width of MemAddr (low ADDR_W bits of the latched address).
- ROM_TOP, 16'h07FF, highest address of the ROM region; the region spans 0..ROM_TOP inclusive.
- ROM_WAIT, 2, wait states for ROM-region accesses (0..15).
- RAM_WAIT, 1, wait states for addresses above ROM_TOP (0..15).

Ports:
- Clock  in  1  system clock, rising edge.
- nReset  in  1  reset, synchronous, active low.
- CpuDataOut  in  16  core bus: address while CpuALE=1, write data otherwise.
- CpuALE  in  1  address latch enable.
- CpuNME  in  1  memory enable, active low; frames one access.
- CpuNOE  in  1  output enable, active low; read strobe.
- CpuRnW  in  1  1=read, 0=write.
- CpuDataIn  out  16  read data to the core.
- CpuNWait  out  1  0 = core must hold the current bus phase.
- MemAddr  out  ADDR_W  external address.
- MemWData  out  16  external write data.
- MemRData  in  16  external read data.
- MemCE_n  out  1  chip enable, active low.
- MemOE_n  out  1  output enable, active low.
- MemWE_n  out  1  write enable, active low.
- WrErr  out  1  one-cycle pulse on a rejected ROM write.

Behaviour:
- Clock/reset: one clock, Clock. nReset is synchronous and active low.
- Reset values: state IDLE; AddrReg, RdReg, WdReg, Cnt all 0; MemCE_n=MemOE_n=MemWE_n=1; CpuNWait=1; WrErr=0; CpuDataIn=0; MemAddr=0; MemWData=0.
- Address latch: at an edge with CpuALE=1 and state=IDLE, AddrReg<=CpuDataOut. CpuALE in any other state is ignored. MemAddr=AddrReg[ADDR_W-1:0] at all times.
- Region: IsRom = (AddrReg <= ROM_TOP); W = IsRom ? ROM_WAIT : RAM_WAIT. The compare is unsigned on 16 bits.
- FSM states: IDLE, ACCESS, DONE.
- IDLE -> ACCESS: at an edge with CpuNME=0 and CpuALE=0. On the same edge:
  - Cnt<=W.
  - Op latched as read when CpuRnW=1, write otherwise.
  - For writes, WdReg<=CpuDataOut.
- ACCESS, all operations:
  - MemCE_n=0 for the whole state.
  - Cnt decrements each edge while nonzero.
  - CpuNWait=0 while Cnt!=0, else 1.
- ACCESS, read: MemOE_n=0 whenever CpuNOE=0. CpuDataIn=MemRData (combinational).
- ACCESS, write outside ROM: MemWE_n=0 and MemWData=WdReg. Write pulse width is W+1 cycles.
- ACCESS, write inside ROM: MemWE_n stays 1. WrErr pulses high for exactly the first ACCESS cycle. The access otherwise completes with normal timing.
- ACCESS -> DONE: at the edge where Cnt==0. For a read, RdReg<=MemRData on that edge.
- DONE:
  - All Mem strobes are 1; CpuNWait=1; CpuDataIn=RdReg.
  - Stays in DONE until CpuNME=1, then goes to IDLE.
- IDLE: CpuDataIn=RdReg; strobes are 1.
- Latency:
  - An access occupies W+1 cycles in ACCESS.
  - W=0 gives no nWait-low cycle, and read data is valid in the first ACCESS cycle.
- Abort: CpuNME=1 while in ACCESS -> IDLE on the next edge. Strobes deassert, RdReg is not updated, Cnt is cleared.
- Reset mid-access: the next edge with nReset=0 forces all reset values. Strobes are high from that edge, with no partial write completion beyond it.
- Simultaneous CpuALE and CpuNME=0 in IDLE: only the latch occurs; the access starts on a later edge with CpuALE=0.
- Back-to-back accesses require a return to IDLE (CpuNME high for at least 1 cycle).

Decomposition:
- Shared package, extended to hold:
  - mem_state_t enum {IDLE, ACCESS, DONE};
  - the ROM_TOP, ROM_WAIT and RAM_WAIT defaults as constants, so the core and the bench share one memory map.
- One natural sub-module: wait_counter. It is a 4-bit loadable down-counter with a zero flag, and is reused later for peripheral wait generation.
- Address decode and strobe logic stay inline.

Test Plan:
- RAM read, RAM_WAIT=1:
  - Stimulus: ALE with 16'h1234; nME=0, nOE=0, RnW=1; MemRData=16'hBEEF.
  - Response: CpuNWait low for exactly 1 cycle; MemOE_n low for 2 cycles; CpuDataIn=16'hBEEF after DONE; MemAddr=16'h1234.
- RAM write:
  - Stimulus: ALE 16'h2000, then CpuDataOut=16'hA5A5, RnW=0, nME=0.
  - Response: MemWE_n low for 2 cycles; MemWData=16'hA5A5; WrErr=0.
- ROM read, ROM_WAIT=2:
  - Stimulus: address 16'h0010.
  - Response: CpuNWait low for 2 cycles, 3 ACCESS cycles.
- ROM write:
  - Stimulus: address 16'h07FF.
  - Response: MemWE_n never low; WrErr high for 1 cycle.
- Boundary address:
  - Stimulus: write to 16'h0800.
  - Response: treated as RAM; MemWE_n low.
- Abort and reset:
  - Stimulus: nME raised in the 1st ACCESS cycle of a ROM read.
  - Response: IDLE next cycle; RdReg unchanged.
  - Stimulus: separately, nReset=0 mid-write.
  - Response: MemWE_n=1 and all outputs at reset values after that edge.
